// File: rtl/uart_rx_cfg.sv
// UART receiver: 2-flop synchroniser, oversampled 3-vote bit recovery, configurable frame,
// parity/framing checks and a valid/ready output register with overrun pulse.
module uart_rx_cfg #(
   parameter int CLK_FREQ   = 1000000,
   parameter int BAUD_RATE  = 9600,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);
   localparam int TICK_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
   localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int OS_W     = $clog2(OVERSAMPLE);
   localparam int HALF     = OVERSAMPLE / 2;
   localparam int BC_W     = 4;

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRK} state_t;

   state_t               state, state_nx;
   logic                 rx_s1, rx_s2;
   logic [DIV_W-1:0]     div_cnt;
   logic [OS_W-1:0]      tick_cnt;
   logic [BC_W-1:0]      bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 v0, v1, perr_acc, ferr_acc;
   logic                 tick, vote_tick, end_tick, maj, last_stop, load, frame_now;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
      end else begin
         rx_s1 <= rx;
         rx_s2 <= rx_s1;
      end
   end

   // Counters idle at zero outside a frame, so the divider phase starts at the start edge.
   assign tick      = (state != S_IDLE) && (state != S_BRK) && (div_cnt == DIV_W'(TICK_DIV - 1));
   assign vote_tick = tick && (tick_cnt == OS_W'(HALF + 1));
   assign end_tick  = tick && (tick_cnt == OS_W'(OVERSAMPLE - 1));
   assign maj       = (v0 & v1) | (v0 & rx_s2) | (v1 & rx_s2);
   assign last_stop = (bit_cnt == BC_W'(STOP_BITS - 1));
   assign load      = (state == S_STOP) && vote_tick && last_stop;
   assign frame_now = ferr_acc | ~maj;
   assign busy      = (state != S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt  <= '0;
         tick_cnt <= '0;
         v0       <= 1'b1;
         v1       <= 1'b1;
      end else if (state == S_IDLE || state == S_BRK) begin
         div_cnt  <= '0;
         tick_cnt <= '0;
      end else if (tick) begin
         div_cnt  <= '0;
         tick_cnt <= (tick_cnt == OS_W'(OVERSAMPLE - 1)) ? '0 : tick_cnt + 1'b1;
         if (tick_cnt == OS_W'(HALF - 1)) v0 <= rx_s2;
         if (tick_cnt == OS_W'(HALF))     v1 <= rx_s2;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (!rx_s2) state_nx = S_START;
         S_START: begin
            if (vote_tick && maj) state_nx = S_IDLE;
            else if (end_tick)    state_nx = S_DATA;
         end
         S_DATA:  if (end_tick && bit_cnt == BC_W'(DATA_BITS - 1))
                     state_nx = (PARITY != 0) ? S_PAR : S_STOP;
         S_PAR:   if (end_tick) state_nx = S_STOP;
         // Leave at the last stop vote so a following start edge is never missed.
         S_STOP:  if (load) state_nx = (frame_now && !rx_s2) ? S_BRK : S_IDLE;
         S_BRK:   if (rx_s2) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt  <= '0;
         shreg    <= '0;
         perr_acc <= 1'b0;
         ferr_acc <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               bit_cnt  <= '0;
               perr_acc <= 1'b0;
               ferr_acc <= 1'b0;
            end
            S_DATA: begin
               if (vote_tick) shreg <= {maj, shreg[DATA_BITS-1:1]};
               if (end_tick)
                  bit_cnt <= (bit_cnt == BC_W'(DATA_BITS - 1)) ? '0 : bit_cnt + 1'b1;
            end
            S_PAR: if (vote_tick)
               perr_acc <= (PARITY == 1) ? ~(^shreg ^ maj) :
                           (PARITY == 2) ?  (^shreg ^ maj) : 1'b0;
            S_STOP: begin
               if (vote_tick) ferr_acc <= frame_now;
               if (end_tick)  bit_cnt  <= bit_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (load) begin
            if (rx_valid && !rx_ready) begin
               overrun <= 1'b1;
            end else begin
               rx_data    <= shreg;
               parity_err <= perr_acc;
               frame_err  <= frame_now;
               rx_valid   <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: an 8N1 instance and an 8E1 instance, scoreboard per instance.
module tb_uart_rx_cfg;
   localparam int TICK_DIV = 1000000 / (9600 * 16);
   localparam int BIT      = TICK_DIV * 16;

   typedef struct packed {logic [7:0] d; logic pe; logic fe;} exp_t;

   logic clk = 1'b0, rst_n = 1'b1;
   logic rx_a = 1'b1, rx_b = 1'b1, rdy_a = 1'b1, rdy_b = 1'b1;
   logic [7:0] data_a, data_b;
   logic val_a, val_b, pe_a, pe_b, fe_a, fe_b, ov_a, ov_b, busy_a, busy_b;

   exp_t q_a[$], q_b[$];
   int n_cmp = 0, n_err = 0, n_rx_a = 0, n_rx_b = 0, ov_cnt = 0;

   always #5 clk = ~clk;

   uart_rx_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(9600), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .OVERSAMPLE(16)) dut (
      .clk(clk), .rst_n(rst_n), .rx(rx_a), .rx_data(data_a), .rx_valid(val_a),
      .rx_ready(rdy_a), .parity_err(pe_a), .frame_err(fe_a), .overrun(ov_a), .busy(busy_a));

   uart_rx_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(9600), .DATA_BITS(8), .PARITY(2),
                 .STOP_BITS(1), .OVERSAMPLE(16)) dut_p (
      .clk(clk), .rst_n(rst_n), .rx(rx_b), .rx_data(data_b), .rx_valid(val_b),
      .rx_ready(rdy_b), .parity_err(pe_b), .frame_err(fe_b), .overrun(ov_b), .busy(busy_b));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clk_n(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Line is left at the stop value so frames can follow back-to-back.
   task automatic send_a(input logic [7:0] d, input logic stop);
      rx_a = 1'b0; clk_n(BIT);
      for (int i = 0; i < 8; i++) begin rx_a = d[i]; clk_n(BIT); end
      rx_a = stop; clk_n(BIT);
   endtask

   task automatic send_b(input logic [7:0] d, input logic p);
      rx_b = 1'b0; clk_n(BIT);
      for (int i = 0; i < 8; i++) begin rx_b = d[i]; clk_n(BIT); end
      rx_b = p;    clk_n(BIT);
      rx_b = 1'b1; clk_n(BIT);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (ov_a) ov_cnt++;
      if (val_a && rdy_a) begin
         n_rx_a++;
         chk("a_word_expected", q_a.size() != 0, 1'b1);
         if (q_a.size() != 0) begin
            e = q_a.pop_front();
            chk("a_data", data_a, e.d);
            chk("a_parity_err", pe_a, e.pe);
            chk("a_frame_err", fe_a, e.fe);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (val_b && rdy_b) begin
         n_rx_b++;
         chk("b_word_expected", q_b.size() != 0, 1'b1);
         if (q_b.size() != 0) begin
            e = q_b.pop_front();
            chk("b_data", data_b, e.d);
            chk("b_parity_err", pe_b, e.pe);
            chk("b_frame_err", fe_b, e.fe);
         end
      end
   end

   initial begin
      int base, k;
      #2 rst_n = 1'b0;
      clk_n(3);
      chk("rst_data", data_a, 8'h00);
      chk("rst_valid", val_a, 1'b0);
      chk("rst_flags", {pe_a, fe_a, ov_a}, 3'b000);
      chk("rst_busy", busy_a, 1'b0);
      rst_n = 1'b1;
      clk_n(BIT);

      // 8N1 back-to-back frames
      q_a.push_back('{8'h55, 1'b0, 1'b0});
      q_a.push_back('{8'hA3, 1'b0, 1'b0});
      send_a(8'h55, 1'b1);
      send_a(8'hA3, 1'b1);
      clk_n(2 * BIT);
      chk("b2b_count", n_rx_a, 2);
      chk("b2b_no_overrun", ov_cnt, 0);

      // even parity: wrong then right parity bit
      q_b.push_back('{8'hA5, 1'b1, 1'b0});
      q_b.push_back('{8'hA5, 1'b0, 1'b0});
      send_b(8'hA5, 1'b1);
      send_b(8'hA5, 1'b0);
      clk_n(2 * BIT);
      chk("par_count", n_rx_b, 2);

      // short low glitch is rejected within one bit time
      base = n_rx_a;
      rx_a = 1'b0; clk_n(10);
      chk("glitch_busy", busy_a, 1'b1);
      clk_n(3 * TICK_DIV - 10);
      rx_a = 1'b1;
      k = 3 * TICK_DIV;
      while (busy_a && k < BIT) begin clk_n(1); k++; end
      chk("glitch_idle", busy_a, 1'b0);
      clk_n(BIT);
      chk("glitch_no_word", n_rx_a, base);

      // framing error followed by a held-low break
      base = n_rx_a;
      q_a.push_back('{8'h5A, 1'b0, 1'b1});
      send_a(8'h5A, 1'b0);
      clk_n(BIT);
      chk("break_busy", busy_a, 1'b1);
      clk_n(2 * BIT);
      rx_a = 1'b1;
      clk_n(2 * BIT);
      chk("break_one_word", n_rx_a, base + 1);
      chk("break_idle", busy_a, 1'b0);
      q_a.push_back('{8'h3C, 1'b0, 1'b0});
      send_a(8'h3C, 1'b1);
      clk_n(2 * BIT);
      chk("after_break_count", n_rx_a, base + 2);

      // overrun while the consumer stalls
      rdy_a = 1'b0;
      base = ov_cnt;
      q_a.push_back('{8'h11, 1'b0, 1'b0});
      send_a(8'h11, 1'b1);
      send_a(8'h22, 1'b1);
      clk_n(BIT);
      chk("ovr_held_data", data_a, 8'h11);
      chk("ovr_held_valid", val_a, 1'b1);
      chk("ovr_pulse_count", ov_cnt, base + 1);
      rdy_a = 1'b1;
      clk_n(2);
      chk("ovr_valid_drop", val_a, 1'b0);

      // reset in the middle of a frame
      base = n_rx_a;
      rx_a = 1'b0; clk_n(BIT);
      rx_a = 1'b0; clk_n(3 * BIT + BIT / 2);
      rst_n = 1'b0;
      clk_n(3);
      chk("mid_rst_data", data_a, 8'h00);
      chk("mid_rst_valid", val_a, 1'b0);
      chk("mid_rst_flags", {pe_a, fe_a, ov_a}, 3'b000);
      chk("mid_rst_busy", busy_a, 1'b0);
      rx_a = 1'b1;
      clk_n(2);
      rst_n = 1'b1;
      clk_n(2 * BIT);
      q_a.push_back('{8'h0F, 1'b0, 1'b0});
      send_a(8'h0F, 1'b1);
      clk_n(2 * BIT);
      chk("rst_one_word", n_rx_a, base + 1);

      chk("a_queue_drained", q_a.size(), 0);
      chk("b_queue_drained", q_b.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
